// File: rtl/load_store_unit.sv
// Data-memory initiator port for the rv32i core: one load/store at a time,
// word-wide bus with byte enables, misaligned split into two beats.
module load_store_unit #(
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        WAIT1,
        REQ2,
        WAIT2,
        RESP
    } state_t;

    state_t      state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [3:0]  r_be_hi;
    logic [31:0] r_wd_hi;
    logic [31:0] r_word0;
    logic        r_two_beat;

    logic [3:0]  acc_mask;
    logic [7:0]  acc_be8;
    logic [63:0] acc_wd64;
    logic        acc_two_beat;
    logic        acc_illegal;

    // Lane placement of the incoming request; the upper half describes beat 2.
    always_comb begin
        acc_mask = 4'b0000;
        case (req_size)
            2'b00:   acc_mask = 4'b0001;
            2'b01:   acc_mask = 4'b0011;
            2'b10:   acc_mask = 4'b1111;
            default: acc_mask = 4'b0000;
        endcase
        acc_be8      = {4'b0000, acc_mask} << req_addr[1:0];
        acc_wd64     = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
        acc_two_beat = |acc_be8[7:4];
        acc_illegal  = (req_size == 2'b11) || (acc_two_beat && !SUPPORT_MISALIGNED);
    end

    function automatic logic [31:0] extend_load(input logic [63:0] words,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] raw;
        raw = 32'(words >> {off, 3'b000});
        case (size)
            2'b00:   extend_load = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   extend_load = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= 4'h0;
            mem_wdata  <= 32'h0;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_sign     <= 1'b0;
            r_off      <= 2'b00;
            r_addr     <= 32'h0;
            r_be_hi    <= 4'h0;
            r_wd_hi    <= 32'h0;
            r_word0    <= 32'h0;
            r_two_beat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_sign     <= req_sign;
                        r_off      <= req_addr[1:0];
                        r_addr     <= {req_addr[31:2], 2'b00};
                        r_be_hi    <= acc_be8[7:4];
                        r_wd_hi    <= acc_wd64[63:32];
                        r_two_beat <= acc_two_beat;
                        if (acc_illegal) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= acc_be8[3:0];
                            mem_wdata <= acc_wd64[31:0];
                            state     <= REQ1;
                        end
                    end
                end
                REQ1: begin
                    if (mem_gnt) begin
                        if (r_write && r_two_beat) begin
                            mem_addr  <= r_addr + 32'd4;
                            mem_be    <= r_be_hi;
                            mem_wdata <= r_wd_hi;
                            state     <= REQ2;
                        end else if (r_write) begin
                            mem_req    <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (mem_rvalid) begin
                        r_word0 <= mem_rdata;
                        if (r_two_beat) begin
                            mem_req   <= 1'b1;
                            mem_addr  <= r_addr + 32'd4;
                            mem_be    <= r_be_hi;
                            mem_wdata <= r_wd_hi;
                            state     <= REQ2;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= extend_load({32'h0, mem_rdata}, r_off, r_size, r_sign);
                            state      <= RESP;
                        end
                    end
                end
                REQ2: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (r_write) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end else begin
                            state <= WAIT2;
                        end
                    end
                end
                WAIT2: begin
                    if (mem_rvalid) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= extend_load({mem_rdata, r_word0}, r_off, r_size, r_sign);
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small memory responder plus one
// task per scenario, each with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        nm_req_valid, nm_req_ready, nm_resp_valid, nm_resp_err;
    logic [31:0] nm_resp_rdata;
    logic        nm_mem_req, nm_mem_we;
    logic [31:0] nm_mem_addr, nm_mem_wdata;
    logic [3:0]  nm_mem_be;
    logic        nm_gnt = 1'b0;
    logic        nm_rvalid = 1'b0;
    logic [31:0] nm_rdata = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.SUPPORT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.SUPPORT_MISALIGNED(1'b0)) dut_nm (
        .clk(clk), .rst(rst),
        .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_write(req_write),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(nm_resp_valid), .resp_rdata(nm_resp_rdata), .resp_err(nm_resp_err),
        .mem_req(nm_mem_req), .mem_gnt(nm_gnt), .mem_we(nm_mem_we), .mem_addr(nm_mem_addr),
        .mem_be(nm_mem_be), .mem_wdata(nm_mem_wdata), .mem_rvalid(nm_rvalid), .mem_rdata(nm_rdata)
    );

    // Memory responder: grants after stall_cycles, returns read data the next cycle.
    bit [31:0]   mem [bit [31:0]];
    int          stall_cycles = 0;
    bit          hold_rvalid  = 1'b0;
    int          req_age      = 0;
    bit          pend         = 1'b0;
    logic [31:0] pend_addr    = 32'h0;
    logic [31:0] beat_addr  [256];
    logic [3:0]  beat_be    [256];
    logic [31:0] beat_wdata [256];
    logic        beat_we    [256];
    int          beat_total = 0;

    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    end

    always @(negedge clk) begin
        bit [31:0] word;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (pend && !hold_rvalid) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
            pend       = 1'b0;
        end
        mem_gnt = 1'b0;
        if (mem_req === 1'b1) begin
            if (req_age >= stall_cycles) begin
                mem_gnt = 1'b1;
                req_age = 0;
                beat_addr[beat_total & 255]  = mem_addr;
                beat_be[beat_total & 255]    = mem_be;
                beat_wdata[beat_total & 255] = mem_wdata;
                beat_we[beat_total & 255]    = mem_we;
                beat_total++;
                if (mem_we) begin
                    word = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (mem_be[i]) word[8*i +: 8] = mem_wdata[8*i +: 8];
                    mem[mem_addr] = word;
                end else begin
                    pend      = 1'b1;
                    pend_addr = mem_addr;
                end
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
    end

    // Presents one request for a single accepted cycle; returns on the negedge after acceptance.
    task automatic issue_req(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_sign = sg;
        req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b1; req_size = 2'b11; req_sign = 1'b1;
        req_addr = 32'h0BAD_F00D; req_wdata = 32'hA5A5_A5A5;
    endtask

    // Waits (bounded) for resp_valid; lat is cycles after acceptance.
    task automatic wait_resp(output bit got, output int lat, output logic [31:0] rd, output logic er);
        got = 1'b0; lat = 1; rd = 32'h0; er = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (resp_valid === 1'b1) begin
                got = 1'b1; rd = resp_rdata; er = resp_err;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_req_ready: got %b expected 1", req_ready); end
        n_checks++; if ({mem_req, mem_we, resp_valid, resp_err} !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_ctrl: got req/we/rv/err=%b expected 0000", {mem_req, mem_we, resp_valid, resp_err}); end
        n_checks++; if ({mem_addr, mem_be, mem_wdata, resp_rdata} !== 100'h0) begin n_fail++; $display("[TB] FAIL rst_data: got addr=%h be=%b wdata=%h rdata=%h expected all 0", mem_addr, mem_be, mem_wdata, resp_rdata); end
    endtask

    task automatic test_aligned_word();
        bit got; int lat; logic [31:0] rd; logic er; int b0;
        b0 = beat_total;
        issue_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        wait_resp(got, lat, rd, er);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_resp: got none expected resp_valid"); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL sw_latency: got %0d expected 2", lat); end
        n_checks++; if (beat_total - b0 !== 1) begin n_fail++; $display("[TB] FAIL sw_beats: got %0d expected 1", beat_total - b0); end
        n_checks++; if ({beat_we[b0 & 255], beat_addr[b0 & 255], beat_be[b0 & 255], beat_wdata[b0 & 255]} !== {1'b1, 32'h100, 4'b1111, 32'hDEADBEEF})
            begin n_fail++; $display("[TB] FAIL sw_beat: got we=%b addr=%h be=%b wdata=%h expected 1/00000100/1111/deadbeef", beat_we[b0 & 255], beat_addr[b0 & 255], beat_be[b0 & 255], beat_wdata[b0 & 255]); end
        n_checks++; if ({er, rd} !== 33'h0) begin n_fail++; $display("[TB] FAIL sw_resp_data: got err=%b rdata=%h expected 0/0", er, rd); end
        @(negedge clk);
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL resp_one_cycle: got %b expected 0", resp_valid); end
        b0 = beat_total;
        issue_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        wait_resp(got, lat, rd, er);
        n_checks++; if (got !== 1'b1 || lat !== 3) begin n_fail++; $display("[TB] FAIL lw_latency: got valid=%b lat=%0d expected 1/3", got, lat); end
        n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_data: got %h err=%b expected deadbeef/0", rd, er); end
        n_checks++; if (beat_we[b0 & 255] !== 1'b0 || beat_be[b0 & 255] !== 4'b1111) begin n_fail++; $display("[TB] FAIL lw_beat: got we=%b be=%b expected 0/1111", beat_we[b0 & 255], beat_be[b0 & 255]); end
    endtask

    task automatic test_byte_lanes();
        bit got; int lat; logic [31:0] rd; logic er; int b0;
        logic [1:0]  sz [5];
        logic        sg [5];
        logic [31:0] ad [5];
        logic [31:0] ex [5];
        logic [3:0]  be [5];
        sz = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        sg = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ad = '{32'h202, 32'h203, 32'h200, 32'h202, 32'h202};
        ex = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01, 32'h000080FF, 32'hFFFF80FF};
        be = '{4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1100};
        issue_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h80FF7F01);
        wait_resp(got, lat, rd, er);
        for (int i = 0; i < 5; i++) begin
            b0 = beat_total;
            issue_req(1'b0, sz[i], sg[i], ad[i], 32'h0);
            wait_resp(got, lat, rd, er);
            n_checks++; if (rd !== ex[i] || got !== 1'b1) begin n_fail++; $display("[TB] FAIL lane_load_%0d: got %h (valid=%b) expected %h", i, rd, got, ex[i]); end
            n_checks++; if (beat_total - b0 !== 1 || beat_be[b0 & 255] !== be[i]) begin n_fail++; $display("[TB] FAIL lane_be_%0d: got beats=%0d be=%b expected 1/%b", i, beat_total - b0, beat_be[b0 & 255], be[i]); end
        end
    endtask

    task automatic test_misaligned();
        bit got; int lat; logic [31:0] rd; logic er; int b0;
        b0 = beat_total;
        issue_req(1'b1, 2'b10, 1'b0, 32'h301, 32'h11223344);
        wait_resp(got, lat, rd, er);
        n_checks++; if (got !== 1'b1 || beat_total - b0 !== 2) begin n_fail++; $display("[TB] FAIL msw_beats: got valid=%b beats=%0d expected 1/2", got, beat_total - b0); end
        n_checks++; if ({beat_addr[b0 & 255], beat_be[b0 & 255], beat_wdata[b0 & 255]} !== {32'h300, 4'b1110, 32'h22334400})
            begin n_fail++; $display("[TB] FAIL msw_beat1: got addr=%h be=%b wdata=%h expected 00000300/1110/22334400", beat_addr[b0 & 255], beat_be[b0 & 255], beat_wdata[b0 & 255]); end
        n_checks++; if ({beat_addr[(b0 + 1) & 255], beat_be[(b0 + 1) & 255], beat_wdata[(b0 + 1) & 255]} !== {32'h304, 4'b0001, 32'h00000011})
            begin n_fail++; $display("[TB] FAIL msw_beat2: got addr=%h be=%b wdata=%h expected 00000304/0001/00000011", beat_addr[(b0 + 1) & 255], beat_be[(b0 + 1) & 255], beat_wdata[(b0 + 1) & 255]); end
        b0 = beat_total;
        issue_req(1'b0, 2'b10, 1'b0, 32'h301, 32'h0);
        wait_resp(got, lat, rd, er);
        n_checks++; if (rd !== 32'h11223344 || got !== 1'b1) begin n_fail++; $display("[TB] FAIL mlw_data: got %h (valid=%b) expected 11223344", rd, got); end
        n_checks++; if (lat !== 5 || beat_addr[(b0 + 1) & 255] !== 32'h304) begin n_fail++; $display("[TB] FAIL mlw_timing: got lat=%0d beat2=%h expected 5/00000304", lat, beat_addr[(b0 + 1) & 255]); end
    endtask

    task automatic test_wrap_stall();
        bit got; int lat; logic [31:0] rd; logic er; int b0;
        b0 = beat_total;
        issue_req(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h000000A5);
        wait_resp(got, lat, rd, er);
        n_checks++; if ({beat_addr[b0 & 255], beat_be[b0 & 255], beat_wdata[b0 & 255]} !== {32'hFFFFFFFC, 4'b1000, 32'hA5000000})
            begin n_fail++; $display("[TB] FAIL sb_top: got addr=%h be=%b wdata=%h expected fffffffc/1000/a5000000", beat_addr[b0 & 255], beat_be[b0 & 255], beat_wdata[b0 & 255]); end
        issue_req(1'b1, 2'b00, 1'b0, 32'h0, 32'h000000C3);
        wait_resp(got, lat, rd, er);
        stall_cycles = 3;
        b0 = beat_total;
        issue_req(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++; if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'hFFFFFFFC, 4'b1000})
                begin n_fail++; $display("[TB] FAIL stall_hold_%0d: got req=%b we=%b addr=%h be=%b expected 1/0/fffffffc/1000", k, mem_req, mem_we, mem_addr, mem_be); end
        end
        wait_resp(got, lat, rd, er);
        stall_cycles = 0;
        n_checks++; if (rd !== 32'hFFFFC3A5 || got !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_data: got %h (valid=%b) expected ffffc3a5", rd, got); end
        n_checks++; if (beat_total - b0 !== 2 || beat_addr[(b0 + 1) & 255] !== 32'h0 || beat_be[(b0 + 1) & 255] !== 4'b0001)
            begin n_fail++; $display("[TB] FAIL wrap_beat2: got beats=%0d addr=%h be=%b expected 2/00000000/0001", beat_total - b0, beat_addr[(b0 + 1) & 255], beat_be[(b0 + 1) & 255]); end
    endtask

    task automatic test_errors();
        bit got; int lat; logic [31:0] rd; logic er; int b0;
        b0 = beat_total;
        issue_req(1'b1, 2'b11, 1'b0, 32'h400, 32'hFFFFFFFF);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_no_req: got mem_req=%b expected 0", mem_req); end
        wait_resp(got, lat, rd, er);
        n_checks++; if ({got, er, rd} !== {2'b11, 32'h0} || lat !== 1) begin n_fail++; $display("[TB] FAIL illegal_resp: got valid=%b err=%b rdata=%h lat=%0d expected 1/1/0/1", got, er, rd, lat); end
        n_checks++; if (beat_total !== b0) begin n_fail++; $display("[TB] FAIL illegal_beats: got %0d expected 0", beat_total - b0); end
        @(negedge clk);
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clear: got %b expected 0", resp_err); end
        n_checks++; if (nm_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL nm_ready: got %b expected 1", nm_req_ready); end
        nm_req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_sign = 1'b0; req_addr = 32'h2;
        @(negedge clk);
        nm_req_valid = 1'b0;
        n_checks++; if ({nm_resp_valid, nm_resp_err, nm_resp_rdata, nm_mem_req} !== {2'b11, 32'h0, 1'b0})
            begin n_fail++; $display("[TB] FAIL nm_resp: got valid=%b err=%b rdata=%h mem_req=%b expected 1/1/0/0", nm_resp_valid, nm_resp_err, nm_resp_rdata, nm_mem_req); end
        @(negedge clk);
        n_checks++; if ({nm_resp_valid, nm_mem_req, nm_mem_we, nm_mem_be, nm_mem_addr, nm_mem_wdata} !== 71'h0)
            begin n_fail++; $display("[TB] FAIL nm_quiet: got rv=%b req=%b we=%b be=%b addr=%h wdata=%h expected all 0", nm_resp_valid, nm_mem_req, nm_mem_we, nm_mem_be, nm_mem_addr, nm_mem_wdata); end
    endtask

    task automatic test_reset_mid_load();
        bit got; int lat; logic [31:0] rd; logic er; bit seen;
        hold_rvalid = 1'b1;
        issue_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL wait1_state: got mem_req=%b resp_valid=%b expected 0/0", mem_req, resp_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold_rvalid = 1'b0;
        n_checks++; if ({req_ready, mem_req, resp_valid} !== 3'b100) begin n_fail++; $display("[TB] FAIL rst_mid: got ready/req/rv=%b expected 100", {req_ready, mem_req, resp_valid}); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1 || mem_req === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0 || pend !== 1'b0) begin n_fail++; $display("[TB] FAIL stray_rvalid: got activity=%b pending=%b expected 0/0", seen, pend); end
        issue_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        wait_resp(got, lat, rd, er);
        n_checks++; if (rd !== 32'hDEADBEEF || got !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_load: got %h (valid=%b) expected deadbeef", rd, got); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; nm_req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'b00; req_sign = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_aligned_word();
        test_byte_lanes();
        test_misaligned();
        test_wrap_stall();
        test_errors();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side data-memory port of the rv32i core.
- Accepts one load/store request at a time from the execute stage and drives a word-wide memory bus with byte enables.
- Splits misaligned accesses into two word beats, merges load beats, and sign- or zero-extends load data.
- Returns a single response per request.

Parameters:
- SUPPORT_MISALIGNED, 1, 1 = split word-crossing accesses into two beats; 0 = report them as an error with no bus activity.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_sign  input  1  1 = unsigned (zero-extend), 0 = signed (sign-extend); loads only.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle pulse: request complete.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: illegal size, or misaligned with SUPPORT_MISALIGNED = 0.
- mem_req  output  1  bus beat request.
- mem_gnt  input  1  bus accepts beat in this cycle.
- mem_we  output  1  beat is a write.
- mem_addr  output  32  word-aligned byte address; bits [1:0] always 0.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-aligned write data.
- mem_rvalid  input  1  read data valid; at least 1 cycle after gnt, in order.
- mem_rdata  input  32  read word.

Behaviour:
- **Reset:** state IDLE. Outputs: req_ready = 1, mem_req = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_we = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0.
- **Reset mid-operation:** returns to IDLE next cycle, mem_req drops, the request is abandoned with no response, and any later mem_rvalid is ignored.
- **Handshake:**
  - req_ready = 1 only in IDLE; a request is accepted on req_valid && req_ready.
  - All request fields are registered at acceptance and the inputs are don't-care afterwards.
- **Beat computation** (off = addr[1:0]; mask = 0001/0011/1111 for byte/half/word):
  - be8 = mask << off; wd64 = zero-extended wdata << 8*off.
  - Beat 1: mem_addr = {addr[31:2], 00}, mem_be = be8[3:0], mem_wdata = wd64[31:0].
  - Beat 2 is needed iff be8[7:4] != 0. It uses mem_addr = beat-1 address + 4, wrapping mod 2^32 (0xFFFFFFFC -> 0x00000000), mem_be = be8[7:4], mem_wdata = wd64[63:32].
- **States:** IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
  - IDLE -> RESP if the request is illegal; otherwise -> REQ1. mem_req rises the cycle after acceptance.
  - REQ1/REQ2:
    - mem_req = 1; mem_we/addr/be/wdata are held stable until mem_gnt.
    - On gnt, a store goes to the next beat or RESP.
    - On gnt, a load goes to WAIT1/WAIT2.
  - WAIT1/WAIT2:
    - mem_req = 0.
    - On mem_rvalid, mem_rdata is captured as word0/word1, and the FSM goes to REQ2 or RESP.
  - RESP:
    - resp_valid = 1 for exactly one cycle, then IDLE.
    - Latency: one cycle after the final gnt (store) or final rvalid (load).
  - Back-to-back: the next request is accepted no earlier than the cycle after RESP.
- **Load assembly:**
  - raw = ({word1, word0} >> 8*off) truncated to 8/16/32 bits; word1 = 0 if there is no beat 2.
  - Result is zero-extended if sign = 1, otherwise sign-extended from bit 7/15.
  - Word loads ignore sign.
- **Errors:**
  - Illegal size, or a two-beat access with SUPPORT_MISALIGNED = 0: no mem_req; the RESP cycle has resp_err = 1 and resp_rdata = 0.
  - resp_err = 0 otherwise.
- mem_rvalid outside the WAIT states is ignored.

Test Plan:
- **Aligned word store/load:** store 0xDEADBEEF at 0x100 (gnt immediate) -> one beat, addr 0x100, be 1111, resp_valid 2 cycles after acceptance. Load 0x100 with rvalid 1 cycle after gnt -> resp_rdata 0xDEADBEEF.
- **Byte lanes/extension:** memory word 0x80FF7F01 at 0x200. lb 0x202 -> 0xFFFFFFFF; lbu 0x203 -> 0x00000080; lh 0x200 -> 0x00007F01; lhu 0x202 -> 0x000080FF.
- **Misaligned store:** sw 0x11223344 at 0x301 -> beat 1 addr 0x300, be 1110, wdata 0x22334400; beat 2 addr 0x304, be 0001, wdata 0x00000011. Then lw 0x301 -> 0x11223344.
- **Wrap and stall:** lh at 0xFFFFFFFF with gnt held low 3 cycles -> mem_req and fields stable while stalled. Beat 2 addr 0x00000000, be 0001; result assembled correctly.
- **Errors:**
  - req_size = 11 -> no mem_req; resp_valid with resp_err = 1 one cycle after acceptance.
  - SUPPORT_MISALIGNED = 0 with lw 0x2 -> same error response.
- **Reset mid-load:** rst asserted in WAIT1 -> next cycle IDLE, req_ready = 1, mem_req = 0, no resp_valid. A stray rvalid afterwards produces no response.
